uart_word_tx: RTL and testbench
===============================

Name: uart_word_tx

Overview:
- Host-side serial feeder sitting directly upstream of the SoC uart block; it drives the uart's datai line.
- Accepts 32-bit words through a valid/ready port and buffers them in a word FIFO.
- Serialises each word as four UART frames, most-significant byte first, in the frame format the uart receiver expects.
- Used by the bench and by the FPGA host bridge to load program/image data into RAM through the uart.

Parameters:
- DEPTH, 16, FIFO depth in 32-bit words; power of two, minimum 2.
- CLKS_PER_BIT, 1, clk cycles per serial bit; minimum 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high; one clock, no other clock domains.
- wdata  input  32  word to transmit.
- wvalid  input  1  wdata valid.
- wready  output  1  FIFO can accept a word; equals !full.
- datao  output  1  serial line to the uart datai; idles high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- level  output  $clog2(DEPTH)+1  words currently held in the FIFO (excludes the word being shifted).
- word_done  output  1  one-cycle pulse on the edge that ends the stop bit of byte 3 of a word.

Behaviour:
- Reset (async, rst=1): datao=1, wready=1, busy=0, level=0, word_done=0, FIFO emptied, FSM to IDLE. Reset mid-frame aborts the frame immediately; the partial byte is lost.
- Push: occurs when wvalid && wready at a rising edge. wvalid while full is ignored and the data is dropped; the source must hold it.
- Simultaneous push and pop: both take effect; level is unchanged.
- FIFO: read/write pointers of $clog2(DEPTH)+1 bits with wrap-around; full when level==DEPTH, empty when level==0.
- FSM states: IDLE, START, DATA, STOP. One bit-timer counts 0..CLKS_PER_BIT-1; each state advances when the timer reaches CLKS_PER_BIT-1.
- IDLE, FIFO non-empty: at the next edge, pop the head word into a 32-bit shift register, set byte index=0, datao=0, go to START.
  - Latency: a word pushed into an empty idle block at edge k gives datao=0 after edge k+1.
- START: datao=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 7.
- DATA: datao = current byte bit[idx], MSB first (bit 7 down to bit 0), CLKS_PER_BIT cycles per bit.
- STOP: datao=1 for CLKS_PER_BIT cycles. Then:
  - If byte index < 3: increment the index, go straight to START (no extra idle bits).
  - If byte index = 3: pulse word_done. If the FIFO is non-empty, pop and go to START on the same edge (back-to-back words); otherwise go to IDLE.
- Byte order per word: wdata[31:24], [23:16], [15:8], [7:0].
- Frame length: 10*CLKS_PER_BIT cycles per byte; 40*CLKS_PER_BIT cycles per word.
- busy = (state != IDLE) || (level != 0).

Optional Feature:
- UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame becomes 11 bits; word becomes 44*CLKS_PER_BIT cycles. The downstream uart must be built with matching parity.
- Undefined: no PARITY state; frame is exactly 10 bits as specified above.

Test Plan:
- Reset then idle: rst pulsed high mid-simulation -> datao=1, busy=0, level=0, wready=1 throughout, no word_done.
- Single word, CLKS_PER_BIT=1: push 32'hF0F0F0F0 at edge k -> datao=0 after k+1; each byte reads 0,1,1,1,1,0,0,0,0,1; word_done after k+40; busy drops the cycle after.
- Byte order: push 32'h12345678 -> decoded bytes 12,34,56,78 in that order; uart writes 32'h12345678 to RAM at 32'h00070000.
- Back-to-back and full: push DEPTH+2 words with wvalid held -> wready low when level=16; no words lost; frames contiguous with no idle bits between words; total 18 word_done pulses.
- Mid-frame reset: assert rst during bit 3 of byte 1 -> datao=1 immediately, level=0; a new word after reset is transmitted cleanly.
- Parity (UART_TX_PARITY_EN), CLKS_PER_BIT=4: push 32'h01010101 -> parity bit 1 after each byte, 176 cycles per word.

Source files
------------

// File: rtl/uart_word_tx.sv
// Word FIFO feeding a UART serialiser, MSB byte first; UART_TX_PARITY_EN adds an even-parity bit per frame.
// Latency: a word pushed into an empty idle block puts the start bit on datao one edge later.
// Backpressure: wready = !full; a word offered while full is not taken and must be held by the source.
module uart_word_tx #(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              wdata,
    input  logic                     wvalid,
    output logic                     wready,
    output logic                     datao,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     word_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TMAX     = TW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bitidx;
    logic [1:0]    byteidx;
    logic [31:0]   shreg;
    logic [7:0]    cur_byte;
    logic          tdone;
    logic          last_stop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign level    = wptr - rptr;
    assign empty    = (wptr == rptr);
    assign full     = (level == FULL_LVL);
    assign wready   = !full;
    assign push     = wvalid && !full;

    assign tdone     = (timer == TMAX);
    assign cur_byte  = shreg[31:24];
    assign last_stop = (state == STOP) && tdone && (byteidx == 2'd3);
    assign pop       = !empty && ((state == IDLE) || last_stop);

    assign word_done = last_stop;
    assign busy      = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bitidx  <= 3'd7;
            byteidx <= 2'd0;
            shreg   <= '0;
            datao   <= 1'b1;
        end else begin
            if (state == IDLE || tdone) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            case (state)
                IDLE: begin
                    datao <= 1'b1;
                    if (!empty) begin
                        shreg   <= mem[rptr[AW-1:0]];
                        byteidx <= 2'd0;
                        datao   <= 1'b0;
                        state   <= START;
                    end
                end

                START: begin
                    if (tdone) begin
                        bitidx <= 3'd7;
                        datao  <= cur_byte[7];
                        state  <= DATA;
                    end
                end

                DATA: begin
                    if (tdone) begin
                        if (bitidx == 3'd0) begin
`ifdef UART_TX_PARITY_EN
                            datao <= ^cur_byte;
                            state <= PARITY;
`else
                            datao <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bitidx <= bitidx - 3'd1;
                            datao  <= cur_byte[bitidx - 3'd1];
                        end
                    end
                end

                PARITY: begin
                    if (tdone) begin
                        datao <= 1'b1;
                        state <= STOP;
                    end
                end

                STOP: begin
                    if (tdone) begin
                        if (byteidx != 2'd3) begin
                            // Next byte of the same word starts with no idle gap.
                            byteidx <= byteidx + 2'd1;
                            shreg   <= {shreg[23:0], 8'h00};
                            datao   <= 1'b0;
                            state   <= START;
                        end else if (!empty) begin
                            shreg   <= mem[rptr[AW-1:0]];
                            byteidx <= 2'd0;
                            datao   <= 1'b0;
                            state   <= START;
                        end else begin
                            datao <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    datao <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: captures the serial line every cycle and decodes it back into bytes.
module tb_uart_word_tx;

    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int CPB = 4;
    localparam int NB  = 11;
`else
    localparam int CPB = 1;
    localparam int NB  = 10;
`endif
    localparam int WORD_CYC = NB * 4 * CPB;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [31:0]            wdata = '0;
    logic                   wvalid = 1'b0;
    logic                   wready;
    logic                   datao;
    logic                   busy;
    logic [$clog2(DEPTH):0] level;
    logic                   word_done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic       line_q [$];
    logic [7:0] dec_bytes [$];
    int         dec_starts [$];
    int         frame_err;
    int         wd_cnt = 0;
    bit         cap = 1'b0;
    int         max_level = 0;
    int         full_bad = 0;

    uart_word_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .datao(datao), .busy(busy), .level(level), .word_done(word_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cap) begin
            line_q.push_back(datao);
            if (word_done) wd_cnt++;
            if (int'(level) > max_level) max_level = int'(level);
            if (int'(level) == DEPTH && wready !== 1'b0) full_bad++;
        end
    end

    // Expected line level for bit position k of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[8-k];
        if (NB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic decode_line();
        int i;
        int n;
        logic [7:0] b;
        dec_bytes.delete();
        dec_starts.delete();
        frame_err = 0;
        n = line_q.size();
        i = 0;
        while (i < n) begin
            if (line_q[i] == 1'b0) begin
                if (i + NB * CPB > n) begin
                    frame_err++;
                    break;
                end
                b = '0;
                for (int j = 0; j < 8; j++) b = {b[6:0], line_q[i + CPB*(1+j) + CPB/2]};
                for (int k = 0; k < NB; k++) begin
                    if (line_q[i + CPB*k + CPB/2] !== frame_bit(b, k)) frame_err++;
                end
                dec_bytes.push_back(b);
                dec_starts.push_back(i);
                i += NB * CPB;
            end else begin
                i++;
            end
        end
    endtask

    task automatic push_hold(input logic [31:0] w, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        wdata  = w;
        wvalid = 1'b1;
        for (int t = 0; t < 4 * WORD_CYC; t++) begin
            if (wready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < bound; t++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset(input string tag);
        int bad;
        bad = 0;
        wvalid = 1'b0;
        wd_cnt = 0;
        cap = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) rst = 1'b0;
            @(negedge clk);
            if (datao !== 1'b1 || busy !== 1'b0 || level !== '0 || wready !== 1'b1 || word_done !== 1'b0) bad++;
        end
        cap = 1'b0;
        total_cnt++;
        if (bad !== 0 || wd_cnt !== 0)
            $display("FAIL %s: %0d bad idle cycles, %0d word_done pulses, required 0 and 0", tag, bad, wd_cnt);
        else pass_cnt++;
    endtask

    task automatic test_single();
        int n;
        bit found;
        int fbad;
        logic [7:0] e;
        line_q.delete();
        wd_cnt = 0;
        cap = 1'b1;
        @(negedge clk);
        wdata  = 32'hF0F0F0F0;
        wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0;
        total_cnt++;
        if (datao !== 1'b1 || level !== 1 || busy !== 1'b1)
            $display("FAIL single_after_push: datao=%b level=%0d busy=%b, required 1 1 1", datao, level, busy);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (datao !== 1'b0 || level !== 0)
            $display("FAIL single_start_latency: datao=%b level=%0d, required 0 0", datao, level);
        else pass_cnt++;
        n = 1;
        found = 1'b0;
        while (n < 4 * WORD_CYC && !found) begin
            if (word_done) found = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        total_cnt++;
        if (!found || n != WORD_CYC)
            $display("FAIL single_word_done_time: found=%0d at %0d, required at %0d", found, n, WORD_CYC);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || word_done !== 1'b0)
            $display("FAIL single_busy_drop: busy=%b word_done=%b, required 0 0", busy, word_done);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        cap = 1'b0;
        decode_line();
        total_cnt++;
        if (dec_bytes.size() != 4 || frame_err != 0 || wd_cnt != 1)
            $display("FAIL single_frames: bytes=%0d framing_errors=%0d word_done=%0d, required 4 0 1", dec_bytes.size(), frame_err, wd_cnt);
        else pass_cnt++;
        fbad = 0;
        e = 8'hF0;
        if (dec_starts.size() > 0) begin
            for (int k = 0; k < NB; k++)
                if (line_q[dec_starts[0] + k*CPB + CPB/2] !== frame_bit(e, k)) fbad++;
        end else fbad = NB;
        total_cnt++;
        if (fbad != 0)
            $display("FAIL single_bit_pattern: %0d wrong bits in first frame, required 0", fbad);
        else pass_cnt++;
    endtask

    task automatic test_byte_order();
        logic [31:0] words [4];
        logic [7:0]  exp_b [$];
        logic [31:0] w;
        bit ok;
        bit all_ok;
        int bad;
        words[0] = 32'h12345678;
        for (int i = 1; i < 4; i++) words[i] = $urandom;
        line_q.delete();
        wd_cnt = 0;
        cap = 1'b1;
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = words[i];
            push_hold(w, ok);
            all_ok &= ok;
            for (int b = 3; b >= 0; b--) exp_b.push_back(w[8*b +: 8]);
            @(negedge clk);
            wvalid = 1'b0;
            repeat ($urandom_range(0, 50)) @(negedge clk);
        end
        wait_idle(8 * WORD_CYC, ok);
        all_ok &= ok;
        repeat (3) @(negedge clk);
        cap = 1'b0;
        total_cnt++;
        if (!all_ok) $display("FAIL order_timeout: push or drain timed out");
        else pass_cnt++;
        decode_line();
        bad = 0;
        for (int i = 0; i < exp_b.size(); i++)
            if (i >= dec_bytes.size() || dec_bytes[i] !== exp_b[i]) bad++;
        total_cnt++;
        if (bad != 0 || dec_bytes.size() != exp_b.size() || frame_err != 0)
            $display("FAIL order_bytes: %0d wrong of %0d decoded (framing errors %0d), required 0 of %0d",
                     bad, dec_bytes.size(), frame_err, exp_b.size());
        else pass_cnt++;
        total_cnt++;
        if (wd_cnt != 4) $display("FAIL order_word_done: %0d pulses, required 4", wd_cnt);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  exp_b [$];
        logic [31:0] w;
        bit ok;
        bit all_ok;
        int bad;
        int gaps;
        line_q.delete();
        wd_cnt = 0;
        max_level = 0;
        full_bad = 0;
        cap = 1'b1;
        all_ok = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            w = $urandom;
            push_hold(w, ok);
            all_ok &= ok;
            for (int b = 3; b >= 0; b--) exp_b.push_back(w[8*b +: 8]);
        end
        @(negedge clk);
        wvalid = 1'b0;
        wait_idle((DEPTH + 4) * WORD_CYC, ok);
        all_ok &= ok;
        repeat (3) @(negedge clk);
        cap = 1'b0;
        total_cnt++;
        if (!all_ok) $display("FAIL b2b_timeout: push or drain timed out");
        else pass_cnt++;
        total_cnt++;
        if (max_level != DEPTH || full_bad != 0)
            $display("FAIL b2b_full: max level %0d, wready high while full %0d times, required %0d and 0", max_level, full_bad, DEPTH);
        else pass_cnt++;
        decode_line();
        bad = 0;
        for (int i = 0; i < exp_b.size(); i++)
            if (i >= dec_bytes.size() || dec_bytes[i] !== exp_b[i]) bad++;
        total_cnt++;
        if (bad != 0 || dec_bytes.size() != exp_b.size() || frame_err != 0)
            $display("FAIL b2b_bytes: %0d wrong of %0d decoded (framing errors %0d), required 0 of %0d",
                     bad, dec_bytes.size(), frame_err, exp_b.size());
        else pass_cnt++;
        gaps = 0;
        for (int i = 1; i < dec_starts.size(); i++)
            if (dec_starts[i] - dec_starts[i-1] != NB * CPB) gaps++;
        total_cnt++;
        if (gaps != 0) $display("FAIL b2b_contiguous: %0d frame gaps, required 0", gaps);
        else pass_cnt++;
        total_cnt++;
        if (wd_cnt != DEPTH + 2) $display("FAIL b2b_word_done: %0d pulses, required %0d", wd_cnt, DEPTH + 2);
        else pass_cnt++;
    endtask

    task automatic test_midframe_reset();
        logic [31:0] w;
        bit ok;
        int bad;
        @(negedge clk);
        wdata  = 32'h00000000;
        wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wdata = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0;
        total_cnt++;
        if (level !== 1) $display("FAIL push_pop_same_edge: level=%0d, required 1", level);
        else pass_cnt++;
        // Now in the first cycle of the word; advance to data bit 3 of byte 1.
        repeat (NB * CPB + 5 * CPB) @(negedge clk);
        total_cnt++;
        if (datao !== 1'b0) $display("FAIL midframe_pre: datao=%b, required 0", datao);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (datao !== 1'b1 || level !== 0 || busy !== 1'b0 || wready !== 1'b1)
            $display("FAIL midframe_reset: datao=%b level=%0d busy=%b wready=%b, required 1 0 0 1", datao, level, busy, wready);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        line_q.delete();
        wd_cnt = 0;
        cap = 1'b1;
        w = $urandom;
        push_hold(w, ok);
        @(negedge clk);
        wvalid = 1'b0;
        wait_idle(4 * WORD_CYC, ok);
        repeat (3) @(negedge clk);
        cap = 1'b0;
        decode_line();
        bad = 0;
        if (dec_bytes.size() == 4) begin
            for (int b = 0; b < 4; b++)
                if (dec_bytes[b] !== w[8*(3-b) +: 8]) bad++;
        end else bad = 4;
        total_cnt++;
        if (!ok || bad != 0 || frame_err != 0 || wd_cnt != 1)
            $display("FAIL post_reset_word: drained=%0d wrong_bytes=%0d framing_errors=%0d word_done=%0d, required 1 0 0 1",
                     ok, bad, frame_err, wd_cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset("reset_initial");
        test_single();
        test_byte_order();
        test_reset("reset_midsim");
        test_back_to_back();
        test_midframe_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
